seven_seg_scan_driver: RTL

Multiplexed N-digit hexadecimal 7-segment display driver with a parameterised digit count and output polarity. It time-division scans the digits with a programmable refresh prescaler and inserts an anti-ghosting blank interval at each digit change. Optional per-digit decimal points, per-digit blanking and leading-zero suppression are supported. New values commit only on frame boundaries, so a frame never shows a mix of old and new digits. It sits between core datapath logic and the board's shared segment/anode pins.

---
 rtl/seven_seg_scan_driver_pkg.sv | 29 ++
 rtl/seven_seg_scan_driver_if.sv | 31 +++
 rtl/seven_seg_scan_driver_seg7_hex_decode.sv | 18 +
 rtl/seven_seg_scan_driver.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver_pkg
// Description : Segment pattern table, segment bit order and digit-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_scan_driver_pkg;

    localparam int SEG_A     = 0;
    localparam int SEG_B     = 1;
    localparam int SEG_C     = 2;
    localparam int SEG_D     = 3;
    localparam int SEG_E     = 4;
    localparam int SEG_F     = 5;
    localparam int SEG_G     = 6;
    localparam int SEG_WIDTH = SEG_G - SEG_A + 1;

    // Active-high g..a patterns, nibble F in the top slice down to nibble 0 at the bottom.
    localparam logic [16*SEG_WIDTH-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int digit_idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver_if
// Description : Data-in and display-pin bundle for the scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_suppress;
    logic [6:0]              seg;
    logic                    seg_dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output value, load, dp_in, blank_in, lz_suppress,
        input  seg, seg_dp, an, pending, frame_done
    );

    modport slave (
        input  value, load, dp_in, blank_in, lz_suppress,
        output seg, seg_dp, an, pending, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_driver_seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational nibble to active-high 7-segment pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seven_seg_scan_driver_pkg::*;
(
    input  wire logic [3:0]           nibble,
    output logic      [SEG_WIDTH-1:0] pattern
);
    logic [6:0] w_base;

    assign w_base  = 7'(nibble) * 7'(SEG_WIDTH) + 7'(SEG_A);
    assign pattern = SEG_TABLE[w_base +: SEG_WIDTH];
endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Multiplexed N-digit hex 7-segment scanner with frame-aligned commit.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input wire logic               clk,
    input wire logic               rst,
    seven_seg_scan_driver_if.slave port_if
);
    localparam int IDX_W   = digit_idx_width(NUM_DIGITS);
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_disp_value, r_pend_value;
    logic [NUM_DIGITS-1:0] r_disp_dp, r_pend_dp;
    logic [NUM_DIGITS-1:0] r_disp_blank, r_pend_blank;
    logic                  r_pending;
    logic                  r_frame_done;
    logic [SEG_WIDTH-1:0]  r_seg;
    logic                  r_seg_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_tick;
    logic                  w_boundary;
    logic [3:0]            w_nibble;
    logic                  w_dark;
    logic                  w_dp;
    logic                  w_upper_zero;
    logic                  w_in_blank;
    logic [NUM_DIGITS-1:0] w_an_hi;
    logic [SEG_WIDTH-1:0]  w_pattern;

    assign w_tick     = (r_presc == C_PRESC_LAST);
    assign w_boundary = w_tick && (r_idx == C_IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // A load on the boundary bypasses the pending stage so it is never a frame late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_boundary) begin
                if (port_if.load) begin
                    r_disp_value <= port_if.value;
                    r_disp_dp    <= port_if.dp_in;
                    r_disp_blank <= port_if.blank_in;
                end else if (r_pending) begin
                    r_disp_value <= r_pend_value;
                    r_disp_dp    <= r_pend_dp;
                    r_disp_blank <= r_pend_blank;
                end
                r_pending <= 1'b0;
            end else if (port_if.load) begin
                r_pend_value <= port_if.value;
                r_pend_dp    <= port_if.dp_in;
                r_pend_blank <= port_if.blank_in;
                r_pending    <= 1'b1;
            end
        end
    end

    // Walk from the top digit down so the all-higher-nibbles-zero term accumulates.
    always_comb begin
        w_nibble     = 4'h0;
        w_dark       = 1'b0;
        w_dp         = 1'b0;
        w_upper_zero = 1'b1;
        w_an_hi      = '0;
        w_in_blank   = (int'(r_presc) < BLANK_CYCLES);
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (r_disp_value[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_nibble   = r_disp_value[4*i +: 4];
                w_dp       = r_disp_dp[i];
                w_dark     = r_disp_blank[i] ||
                             (port_if.lz_suppress && w_upper_zero && (i != 0));
                w_an_hi[i] = !w_dark && !w_in_blank;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble  (w_nibble),
        .pattern (w_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg    <= {SEG_WIDTH{SEG_ACTIVE_LOW}};
            r_seg_dp <= SEG_ACTIVE_LOW;
            r_an     <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            r_seg    <= (w_dark ? '0 : w_pattern) ^ {SEG_WIDTH{SEG_ACTIVE_LOW}};
            r_seg_dp <= (w_dp && !w_dark) ^ SEG_ACTIVE_LOW;
            r_an     <= w_an_hi ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end

    assign port_if.seg        = r_seg;
    assign port_if.seg_dp     = r_seg_dp;
    assign port_if.an         = r_an;
    assign port_if.pending    = r_pending;
    assign port_if.frame_done = r_frame_done;
endmodule
`default_nettype wire
